// File: rtl/caxi4interconnect_cdc_pkg.sv
// rtl/caxi4interconnect_cdc_pkg.sv - shared Gray/binary helpers and sizing for the CDC FIFO controllers
package caxi4interconnect_cdc_pkg;

    // Widest pointer any controller may use (ADDR_WIDTH up to 8, plus wrap bit).
    localparam int PTR_MAX_W = 9;

    // FIFO depth for a given address width; each controller derives its local DEPTH from this.
    function automatic int cdc_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Narrower pointers are zero-extended by the caller, which leaves the conversion unchanged.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/caxi4interconnect_cdc_gray_sync.sv
// rtl/caxi4interconnect_cdc_gray_sync.sv - N-stage synchroniser for a Gray-coded pointer
module caxi4interconnect_cdc_gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Plain shift chain; only one bit of a Gray pointer changes per step, so metastability resolves to old or new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/caxi4interconnect_cdc_rd_ctrl_fwft.sv
// rtl/caxi4interconnect_cdc_rd_ctrl_fwft.sv - read-domain FWFT controller for the CDC FIFO
module caxi4interconnect_cdc_rd_ctrl_fwft
    import caxi4interconnect_cdc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  terminate,
    input  logic [ADDR_WIDTH:0]   wrPtr_gray,
    input  logic                  readyForOut,
    output logic                  infoOutValid,
    output logic                  ramRe,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [ADDR_WIDTH:0]   rdPtr_gray,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almostEmpty
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = cdc_depth(ADDR_WIDTH);
    // Thresholds above DEPTH would make almostEmpty constant; clamp so the compare stays in range.
    localparam logic [PW-1:0] AE_T = (AE_THRESH > DEPTH) ? PW'(DEPTH) : PW'(AE_THRESH);

    logic [PW-1:0] rd_bin_q, rd_bin_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic          valid_q, valid_d;
    logic [PW-1:0] wr_sync;
    logic [PW-1:0] wr_bin;
    logic          ram_empty;
    logic          ram_re;

    caxi4interconnect_cdc_gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk (clk),
        .rst (rst),
        .d_i (wrPtr_gray),
        .q_o (wr_sync)
    );

    // Fetch whenever data exists and the output slot is free or being drained; flush jumps to the write pointer.
    always_comb begin
        wr_bin    = PW'(gray2bin(PTR_MAX_W'(wr_sync)));
        ram_empty = (rd_gray_q == wr_sync);
        ram_re    = !ram_empty && (!valid_q || readyForOut) && !terminate;
        rd_bin_d  = rd_bin_q;
        rd_gray_d = rd_gray_q;
        valid_d   = valid_q;
        if (terminate) begin
            rd_bin_d  = wr_bin;
            rd_gray_d = wr_sync;
            valid_d   = 1'b0;
        end else if (ram_re) begin
            rd_bin_d  = rd_bin_q + PW'(1);
            rd_gray_d = PW'(bin2gray(PTR_MAX_W'(rd_bin_d)));
            valid_d   = 1'b1;
        end else if (readyForOut) begin
            valid_d   = 1'b0;
        end
    end

    // Pointer and valid registers; the Gray pointer leaves this domain straight from its flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            valid_q   <= valid_d;
        end
    end

    assign ramRe        = ram_re;
    assign infoOutValid = valid_q;
    assign rdAddr       = rd_bin_q[ADDR_WIDTH-1:0];
    assign rdPtr_gray   = rd_gray_q;
    assign level        = wr_bin - rd_bin_q;
    assign almostEmpty  = (level <= AE_T);

endmodule

// File: tb/tb_caxi4interconnect_cdc_rd_ctrl_fwft.sv
// tb/tb_caxi4interconnect_cdc_rd_ctrl_fwft.sv - self-checking bench for the FWFT read controller
module tb_caxi4interconnect_cdc_rd_ctrl_fwft;

    localparam int AW = 3;
    localparam int SS = 2;
    localparam int AE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       terminate = 1'b0;
    logic [3:0] wrPtr_gray = '0;
    logic       readyForOut = 1'b0;
    logic       infoOutValid;
    logic       ramRe;
    logic [2:0] rdAddr;
    logic [3:0] rdPtr_gray;
    logic [3:0] level;
    logic       almostEmpty;

    always #5 clk = ~clk;

    caxi4interconnect_cdc_rd_ctrl_fwft #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS),
        .AE_THRESH   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .terminate    (terminate),
        .wrPtr_gray   (wrPtr_gray),
        .readyForOut  (readyForOut),
        .infoOutValid (infoOutValid),
        .ramRe        (ramRe),
        .rdAddr       (rdAddr),
        .rdPtr_gray   (rdPtr_gray),
        .level        (level),
        .almostEmpty  (almostEmpty)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: counts of entries written, visible, and fetched (mod 16).
    int wr = 0;
    int m_rd = 0;
    int m_valid = 0;
    int m_vis = 0;
    int m_pipe [SS];

    logic       e_re, e_valid, e_ae;
    logic [2:0] e_addr;
    logic [3:0] e_level, e_gray;
    logic       o_re, o_valid, o_ae;
    logic [2:0] o_addr;
    logic [3:0] o_level, o_gray;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // One clock: drive inputs, compute expectations, sample DUT, advance model at the edge.
    task automatic cycle(input logic rdy, input logic term, input logic rs);
        int avail;
        readyForOut = rdy;
        terminate   = term;
        rst         = rs;
        wrPtr_gray  = to_gray(wr);
        #1;
        avail   = (m_vis - m_rd) & 15;
        e_level = avail[3:0];
        e_valid = (m_valid != 0);
        e_addr  = m_rd[2:0];
        e_gray  = to_gray(m_rd);
        e_re    = (avail > 0) && (m_valid == 0 || rdy) && !term;
        e_ae    = (avail <= AE);
        o_re = ramRe; o_valid = infoOutValid; o_ae = almostEmpty;
        o_addr = rdAddr; o_level = level; o_gray = rdPtr_gray;
        @(posedge clk);
        if (rs) begin
            m_rd = 0; m_valid = 0; m_vis = 0;
            for (int i = 0; i < SS; i++) m_pipe[i] = 0;
        end else begin
            if (term) begin
                m_rd = m_vis; m_valid = 0;
            end else if (e_re) begin
                m_rd = (m_rd + 1) & 15; m_valid = 1;
            end else if (rdy) begin
                m_valid = 0;
            end
            for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = wr;
            m_vis = m_pipe[SS-1];
        end
        #1;
    endtask

    task automatic test_reset();
        wr = 0;
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
        tests++; if (o_re !== 1'b0) begin fails++; $display("FAIL reset_ramre: got %0b expected 0", o_re); end
        tests++; if (o_gray !== 4'd0) begin fails++; $display("FAIL reset_gray: got %0d expected 0", o_gray); end
        tests++; if (o_level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", o_level); end
        tests++; if (o_ae !== 1'b1) begin fails++; $display("FAIL reset_ae: got %0b expected 1", o_ae); end
        tests++; if (o_addr !== 3'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", o_addr); end
    endtask

    task automatic test_single();
        int re_cnt = 0, re_cyc = -1, v_cnt = 0, v_cyc = -1;
        logic [2:0] re_addr = '1;
        wr = 1;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (o_re) begin re_cnt++; re_cyc = c; re_addr = o_addr; end
            if (o_valid) begin v_cnt++; v_cyc = c; end
        end
        cycle(1'b1, 1'b0, 1'b0);
        tests++; if (re_cnt != 1 || re_cyc != SS) begin fails++; $display("FAIL single_ramre: got count %0d cycle %0d expected 1 at %0d", re_cnt, re_cyc, SS); end
        tests++; if (re_addr !== 3'd0) begin fails++; $display("FAIL single_addr: got %0d expected 0", re_addr); end
        tests++; if (v_cnt != 1 || v_cyc != SS + 1) begin fails++; $display("FAIL single_valid: got count %0d cycle %0d expected 1 at %0d", v_cnt, v_cyc, SS + 1); end
        tests++; if (o_gray !== 4'd1) begin fails++; $display("FAIL single_gray: got %0d expected 1", o_gray); end
        tests++; if (o_level !== 4'd0) begin fails++; $display("FAIL single_level: got %0d expected 0", o_level); end
    endtask

    task automatic test_burst_backpressure();
        int fq [$];
        int re_cnt = 0, x_cnt = 0, x_first = -1, x_last = -1;
        wr = 0;
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        wr = 8;
        for (int c = 0; c < 7; c++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (c == SS) begin
                tests++; if (o_level !== 4'd8) begin fails++; $display("FAIL burst_level_full: got %0d expected 8", o_level); end
            end
            if (o_re) begin re_cnt++; fq.push_back(int'(o_addr)); end
        end
        tests++; if (re_cnt != 1) begin fails++; $display("FAIL burst_bp_fetches: got %0d expected 1", re_cnt); end
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (c == 0) begin
                tests++; if (o_valid !== 1'b1 || o_level !== 4'd7) begin fails++; $display("FAIL burst_bp_hold: got valid %0b level %0d expected 1 7", o_valid, o_level); end
            end
            if (o_re) fq.push_back(int'(o_addr));
            if (o_valid) begin x_cnt++; if (x_first < 0) x_first = c; x_last = c; end
        end
        tests++; if (x_cnt != 8 || x_first != 0 || x_last != 7) begin fails++; $display("FAIL burst_transfers: got %0d from %0d to %0d expected 8 from 0 to 7", x_cnt, x_first, x_last); end
        tests++; if (fq.size() != 8) begin fails++; $display("FAIL burst_fetch_count: got %0d expected 8", fq.size()); end
        for (int i = 0; i < fq.size() && i < 8; i++) begin
            tests++; if (fq[i] != i) begin fails++; $display("FAIL burst_addr_order: got %0d expected %0d", fq[i], i); end
        end
    endtask

    task automatic test_wrap();
        int reads = 0, prev = -1, wraps = 0, msb_toggles = 0;
        logic last_msb;
        last_msb = to_gray(m_rd) >= 4'd8;
        for (int c = 0; c < 200 && reads < 20; c++) begin
            if (((wr - m_rd) & 15) < 8) wr = (wr + 1) & 15;
            cycle(1'b1, 1'b0, 1'b0);
            tests++; if (o_re !== e_re || o_valid !== e_valid || o_addr !== e_addr) begin
                fails++; $display("FAIL wrap_step: got re %0b v %0b a %0d expected %0b %0b %0d", o_re, o_valid, o_addr, e_re, e_valid, e_addr);
            end
            if (o_gray[3] !== last_msb) msb_toggles++;
            last_msb = o_gray[3];
            if (o_re) begin
                if (prev == 7 && o_addr == 3'd0) wraps++;
                if (prev >= 0 && int'(o_addr) != ((prev + 1) & 7)) begin
                    tests++; fails++; $display("FAIL wrap_seq: got %0d expected %0d", o_addr, (prev + 1) & 7);
                end
                prev = int'(o_addr);
                reads++;
            end
        end
        tests++; if (reads != 20) begin fails++; $display("FAIL wrap_reads: got %0d expected 20", reads); end
        tests++; if (wraps < 1) begin fails++; $display("FAIL wrap_addr: got %0d wraps expected at least 1", wraps); end
        tests++; if (msb_toggles < 1) begin fails++; $display("FAIL wrap_msb: got %0d toggles expected at least 1", msb_toggles); end
    endtask

    task automatic test_terminate();
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        wr = (m_rd + 6) & 15;
        repeat (SS + 2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        tests++; if (o_valid !== 1'b1 || o_level !== 4'd5) begin fails++; $display("FAIL term_setup: got valid %0b level %0d expected 1 5", o_valid, o_level); end
        tests++; if (o_re !== 1'b0) begin fails++; $display("FAIL term_ramre: got %0b expected 0", o_re); end
        cycle(1'b0, 1'b0, 1'b0);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL term_valid: got %0b expected 0", o_valid); end
        tests++; if (o_level !== 4'd0) begin fails++; $display("FAIL term_level: got %0d expected 0", o_level); end
        tests++; if (o_gray !== to_gray(wr)) begin fails++; $display("FAIL term_gray: got %0d expected %0d", o_gray, to_gray(wr)); end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b0, 1'b0);
            tests++; if (o_re !== 1'b0 || o_valid !== 1'b0) begin fails++; $display("FAIL term_idle: got re %0b valid %0b expected 0 0", o_re, o_valid); end
        end
    endtask

    task automatic test_almost_empty();
        wr = (wr + 1) & 15;
        repeat (SS + 2) cycle(1'b0, 1'b0, 1'b0);
        tests++; if (o_valid !== 1'b1 || o_level !== 4'd0) begin fails++; $display("FAIL ae_prime: got valid %0b level %0d expected 1 0", o_valid, o_level); end
        wr = (wr + 2) & 15;
        repeat (SS + 1) cycle(1'b0, 1'b0, 1'b0);
        tests++; if (o_level !== 4'd2 || o_ae !== 1'b1) begin fails++; $display("FAIL ae_at2: got level %0d ae %0b expected 2 1", o_level, o_ae); end
        wr = (wr + 1) & 15;
        repeat (SS + 1) cycle(1'b0, 1'b0, 1'b0);
        tests++; if (o_level !== 4'd3 || o_ae !== 1'b0) begin fails++; $display("FAIL ae_at3: got level %0d ae %0b expected 3 0", o_level, o_ae); end
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        tests++; if (o_level !== 4'd2 || o_ae !== 1'b1) begin fails++; $display("FAIL ae_back2: got level %0d ae %0b expected 2 1", o_level, o_ae); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int r;
            logic rs, term, rdy;
            r    = $urandom_range(0, 99);
            rs   = (r < 2);
            term = (r >= 2 && r < 6);
            rdy  = ($urandom_range(0, 3) != 0);
            if (rs) wr = 0;
            else if ($urandom_range(0, 2) != 0 && ((wr - m_rd) & 15) < 8) wr = (wr + 1) & 15;
            cycle(rdy, term, rs);
            tests++; if (o_re !== e_re) begin fails++; $display("FAIL rand_ramre: got %0b expected %0b", o_re, e_re); end
            tests++; if (o_valid !== e_valid) begin fails++; $display("FAIL rand_valid: got %0b expected %0b", o_valid, e_valid); end
            tests++; if (o_addr !== e_addr) begin fails++; $display("FAIL rand_addr: got %0d expected %0d", o_addr, e_addr); end
            tests++; if (o_level !== e_level) begin fails++; $display("FAIL rand_level: got %0d expected %0d", o_level, e_level); end
            tests++; if (o_ae !== e_ae) begin fails++; $display("FAIL rand_ae: got %0b expected %0b", o_ae, e_ae); end
            tests++; if (o_gray !== e_gray) begin fails++; $display("FAIL rand_gray: got %0d expected %0d", o_gray, e_gray); end
        end
    endtask

    initial begin
        for (int i = 0; i < SS; i++) m_pipe[i] = 0;
        test_reset();
        test_single();
        test_burst_backpressure();
        test_wrap();
        test_terminate();
        test_almost_empty();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
